// File: rtl/func_gen_ctrl.sv
// Configuration / sweep scheduler for the function generator core.
// Requests are staged in a shadow and applied only on waveform boundaries.
module func_gen_ctrl #(
  parameter int unsigned MAX_CNT_TABLE = 9999,
  parameter int unsigned MAX_CNT_PULSE = 499999,
  parameter int unsigned DWELL_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_sig_type,
  input  logic [31:0]        cfg_count,
  input  logic [7:0]         cfg_duty,
  input  logic               cfg_sweep,
  input  logic [31:0]        cfg_stop,
  input  logic [31:0]        cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               boundary,
  input  logic               abort,
  output logic [31:0]        set_count,
  output logic [7:0]         duty_cycle,
  output logic [1:0]         sig_type,
  output logic               busy,
  output logic               apply_done,
  output logic               sweep_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE, PEND, SWEEP, SPEND
  } state_t;

  typedef struct packed {
    logic [1:0]         typ;
    logic [31:0]        count;
    logic [7:0]         duty;
    logic               sweep;
    logic [31:0]        start;
    logic [31:0]        stop;
    logic [31:0]        step;
    logic [DWELL_W-1:0] dwell;
    logic               loop_en;
  } shadow_t;

  state_t             state_q, state_d;
  shadow_t            sh_q, sh_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [31:0]        set_count_q, set_count_d;
  logic [7:0]         duty_q, duty_d;
  logic [1:0]         type_q, type_d;
  logic               apply_q, apply_d;
  logic               sdone_q, sdone_d;
  logic               err_q, err_d;

  logic [31:0] lim;
  logic        req_ok;
  logic [32:0] nxt;

  always_comb begin
    lim = cfg_sig_type[1] ? 32'(MAX_CNT_PULSE)
                          : 32'(MAX_CNT_TABLE);
    if (cfg_sweep)
      req_ok = (cfg_count <= cfg_stop) &&
               (cfg_stop <= lim) &&
               (cfg_step != '0) &&
               (cfg_dwell != '0);
    else
      req_ok = cfg_count <= lim;
    // 33-bit sum so a wrap past 2^32 still compares above stop
    nxt = {1'b0, set_count_q} + {1'b0, sh_q.step};
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    dwell_d     = dwell_q;
    set_count_d = set_count_q;
    duty_d      = duty_q;
    type_d      = type_q;
    apply_d     = 1'b0;
    sdone_d     = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            sh_d.typ     = cfg_sig_type;
            sh_d.count   = cfg_count;
            sh_d.duty    = cfg_duty;
            sh_d.sweep   = cfg_sweep;
            sh_d.start   = cfg_count;
            sh_d.stop    = cfg_stop;
            sh_d.step    = cfg_step;
            sh_d.dwell   = cfg_dwell;
            sh_d.loop_en = cfg_loop;
            state_d      = PEND;
          end
        end
      end
      PEND, SPEND: begin
        if (abort) begin
          sh_d    = '0;
          state_d = IDLE;
        end else if (boundary) begin
          set_count_d = sh_q.count;
          duty_d      = sh_q.duty;
          type_d      = sh_q.typ;
          apply_d     = 1'b1;
          dwell_d     = '0;
          state_d     = sh_q.sweep ? SWEEP : IDLE;
        end
      end
      SWEEP: begin
        if (abort) begin
          sh_d    = '0;
          state_d = IDLE;
        end else if (dwell_q == sh_q.dwell - DWELL_W'(1)) begin
          dwell_d = '0;
          if (nxt <= {1'b0, sh_q.stop}) begin
            sh_d.count = nxt[31:0];
            state_d    = SPEND;
          end else if (sh_q.loop_en) begin
            sh_d.count = sh_q.start;
            state_d    = SPEND;
          end else begin
            sdone_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      dwell_q     <= '0;
      set_count_q <= '0;
      duty_q      <= 8'd128;
      type_q      <= '0;
      apply_q     <= 1'b0;
      sdone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      dwell_q     <= dwell_d;
      set_count_q <= set_count_d;
      duty_q      <= duty_d;
      type_q      <= type_d;
      apply_q     <= apply_d;
      sdone_q     <= sdone_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign set_count  = set_count_q;
  assign duty_cycle = duty_q;
  assign sig_type   = type_q;
  assign apply_done = apply_q;
  assign sweep_done = sdone_q;
  assign cfg_err    = err_q;

endmodule

// File: doc/func_gen_ctrl.md
Name: func_gen_ctrl

Overview:
- Configuration and sweep scheduler in front of the function generator core.
- Accepts configuration requests (waveform type, count, duty cycle, optional linear frequency sweep) over a valid/ready handshake and validates them against per-waveform count limits.
- Valid requests are staged in a shadow register and applied atomically to the generator's set_count / duty_cycle / sig_type inputs only on a waveform boundary pulse, so the output never glitches mid-period.
- In sweep mode it steps set_count from start to stop after a programmable dwell.

Parameters:
- MAX_CNT_TABLE, 9999, maximum legal count for SINE(0) and TRIANGLE(1).
- MAX_CNT_PULSE, 499999, maximum legal count for SQUARE(2) and PWM(3).
- DWELL_W, 32, width of the dwell counter and dwell input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  configuration request valid
- cfg_ready  out  1  controller can accept a request
- cfg_sig_type  in  2  waveform: 0 SINE, 1 TRIANGLE, 2 SQUARE, 3 PWM
- cfg_count  in  32  fixed count, or sweep start count
- cfg_duty  in  8  duty cycle
- cfg_sweep  in  1  1 = sweep request
- cfg_stop  in  32  sweep stop count
- cfg_step  in  32  sweep increment
- cfg_dwell  in  DWELL_W  clocks held at each sweep point
- cfg_loop  in  1  1 = restart the sweep at start after stop; 0 = single pass
- boundary  in  1  one-cycle pulse at waveform period end, driven by the generator
- abort  in  1  cancel pending request or sweep
- set_count  out  32  to generator
- duty_cycle  out  8  to generator
- sig_type  out  2  to generator
- busy  out  1  state is not IDLE
- apply_done  out  1  one-cycle pulse each time the outputs update
- sweep_done  out  1  one-cycle pulse when a single-pass sweep ends
- cfg_err  out  1  sticky flag: a request was rejected

Behaviour:
Reset (rst_n low at a clk edge):
- set_count=0, duty_cycle=128, sig_type=0, state=IDLE.
- cfg_ready=1, busy=0, apply_done=0, sweep_done=0, cfg_err=0.
- Shadow registers and dwell counter are cleared.
- Reset overrides every other input, including during PEND or a sweep.

Limit selection:
- LIM = MAX_CNT_TABLE when cfg_sig_type < 2, else MAX_CNT_PULSE.
- Fixed request is valid iff cfg_count <= LIM.
- Sweep request is valid iff all hold: cfg_count <= cfg_stop, cfg_stop <= LIM, cfg_step != 0, cfg_dwell != 0.

States:
- IDLE: cfg_ready=1. A handshake is cfg_valid & cfg_ready.
  - Invalid request: set cfg_err, stay IDLE, outputs unchanged.
  - Valid request: latch all cfg_* into the shadow, go to PEND.
- PEND: cfg_ready=0.
  - On boundary: set_count / duty_cycle / sig_type take the shadow values on the next clk edge (1-cycle latency) and apply_done pulses.
  - Then go to SWEEP if shadow sweep=1, else IDLE.
  - The dwell counter loads 0 on entry to SWEEP.
- SWEEP: the dwell counter increments each clk. When it reaches dwell-1:
  - next = set_count + step, computed in 33 bits to catch overflow.
  - If next <= stop: shadow count = next, go to SPEND.
  - Else if loop=1: shadow count = start, go to SPEND.
  - Else: pulse sweep_done, go to IDLE; set_count stays at its last value.
- SPEND: as PEND, but the apply returns to SWEEP with the dwell counter cleared.

Boundary conditions:
- A boundary arriving in the same cycle as a handshake in IDLE is ignored; the apply waits for the next boundary.
- abort in PEND/SWEEP/SPEND: go to IDLE next cycle, drop the shadow, leave outputs unchanged, no apply_done. abort has priority over a simultaneous boundary.
- abort in IDLE has no effect.
- cfg_err clears only on reset.
- boundary outside PEND/SPEND is ignored.
- Sweep points never exceed stop. With stop=start the sweep holds at start for each dwell; in loop mode it reapplies start each dwell.

Test Plan:
1. Reset, then request type=0, count=500; pulse boundary 10 cycles later -> set_count stays 0 until the cycle after boundary, then becomes 500 with sig_type=0; apply_done pulses exactly once; cfg_ready returns to 1.
2. Request type=1, count=10000 -> cfg_err=1, outputs unchanged, state stays IDLE. Then request type=2, count=10000 -> accepted and applied on the next boundary.
3. Sweep: type=0, start=100, stop=130, step=10, dwell=4, loop=0, with boundary pulsed every cycle -> set_count goes 100,110,120,130, each held ≥4 cycles; sweep_done pulses once; final set_count=130; busy=0 afterwards.
4. Same sweep with loop=1 -> sequence 100,110,120,130,100,110…; abort mid-sweep -> set_count frozen at its current value, busy=0 next cycle, no further apply_done.
5. In PEND, assert abort and boundary in the same cycle -> no apply; outputs keep their old values; state returns to IDLE.
6. Assert rst_n=0 during SPEND -> all outputs return to reset values on the next edge (duty_cycle=128), cfg_err=0, cfg_ready=1.
